// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display blocks: glyph codes,
// pin widths and the all-dark anode/cathode patterns.
package sseg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int CODE_W     = 4;
  localparam int SEG_W      = 7;

  localparam logic [CODE_W-1:0] GLYPH_R = 4'hA;
  localparam logic [CODE_W-1:0] GLYPH_S = 4'hB;
  localparam logic [CODE_W-1:0] GLYPH_Y = 4'hC;
  localparam logic [CODE_W-1:0] GLYPH_D = 4'hD;
  localparam logic [CODE_W-1:0] GLYPH_T = 4'hE;
  localparam logic [CODE_W-1:0] GLYPH_G = 4'hF;

  localparam logic [SEG_W-1:0]      SEG_OFF = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;
endpackage

// File: rtl/sseg_glyph_rom.sv
// Combinational glyph decode: 4-bit code to active-low cathodes {g,f,e,d,c,b,a}.
module sseg_glyph_rom
  import sseg_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_seg
);
  always_comb begin
    o_seg = SEG_OFF;
    case (i_code)
      4'h0:    o_seg = 7'b1000000;
      4'h1:    o_seg = 7'b1111001;
      4'h2:    o_seg = 7'b0100100;
      4'h3:    o_seg = 7'b0110000;
      4'h4:    o_seg = 7'b0011001;
      4'h5:    o_seg = 7'b0010010;
      4'h6:    o_seg = 7'b0000010;
      4'h7:    o_seg = 7'b1111000;
      4'h8:    o_seg = 7'b0000000;
      4'h9:    o_seg = 7'b0010000;
      GLYPH_R: o_seg = 7'b0101111;
      GLYPH_S: o_seg = 7'b0010010;
      GLYPH_Y: o_seg = 7'b0010001;
      GLYPH_D: o_seg = 7'b0100001;
      GLYPH_T: o_seg = 7'b0000111;
      GLYPH_G: o_seg = 7'b1000010;
      default: o_seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with per-frame input
// snapshot, leading dead band per digit slot, and registered pin outputs.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 4
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CODE_W-1:0]     A,
  input  logic [CODE_W-1:0]     B,
  input  logic [CODE_W-1:0]     C,
  input  logic [CODE_W-1:0]     D,
  input  logic [NUM_DIGITS-1:0] blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  frame_start
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]                       r_cnt;
  logic [1:0]                          r_ptr;
  logic [NUM_DIGITS-1:0][CODE_W-1:0]   r_code;
  logic [NUM_DIGITS-1:0]               r_blank;
  logic [NUM_DIGITS-1:0]               r_an;
  logic [SEG_W-1:0]                    r_seg;
  logic                                r_fs;

  logic                                w_fs;
  logic                                w_dark;
  logic [NUM_DIGITS-1:0][CODE_W-1:0]   w_code_in;
  logic [NUM_DIGITS-1:0][CODE_W-1:0]   w_code_cur;
  logic [NUM_DIGITS-1:0]               w_blank_cur;
  logic [CODE_W-1:0]                   w_sel_code;
  logic                                w_sel_blank;
  logic [SEG_W-1:0]                    w_glyph;

  assign w_fs      = (r_ptr == 2'd3) && (r_cnt == '0);
  assign w_code_in = {A, B, C, D};

  generate
    if (DEAD_CYCLES == 0) begin : g_nodead
      assign w_dark = 1'b0;
    end else begin : g_dead
      assign w_dark = (r_cnt < CW'(DEAD_CYCLES));
    end
  endgenerate

  // Prescaler and digit pointer; ptr counts down 3..0 and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_ptr <= 2'd3;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_ptr <= r_ptr - 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code  <= '0;
      r_blank <= AN_OFF;
    end else if (w_fs) begin
      r_code  <= w_code_in;
      r_blank <= blank;
    end
  end

  // On the snapshot cycle itself, decode the values being captured so that
  // a zero dead band never shows one cycle of the previous frame's digit.
  assign w_code_cur  = w_fs ? w_code_in : r_code;
  assign w_blank_cur = w_fs ? blank     : r_blank;
  assign w_sel_code  = w_code_cur[r_ptr];
  assign w_sel_blank = w_blank_cur[r_ptr];

  sseg_glyph_rom u_rom (
    .i_code (w_sel_code),
    .o_seg  (w_glyph)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_fs  <= 1'b0;
    end else begin
      r_fs <= w_fs;
      if (w_dark || w_sel_blank) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
      end else begin
        r_an  <= ~(4'b0001 << r_ptr);
        r_seg <= w_glyph;
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_start = r_fs;
endmodule
